bcd_down_counter: RTL and testbench
===================================

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 The block SHALL have parameter INIT_VAL, default 8'h30, giving the two-digit packed BCD value (tens in [7:4], ones in [3:0]) loaded at reset.
REQ-002 The block SHALL have port clk_out  input  1  count clock; one decrement per rising edge while running.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port load  input  1  synchronous load of preset digits.
REQ-005 The block SHALL have port preset_tens  input  4  BCD tens digit to load.
REQ-006 The block SHALL have port preset_ones  input  4  BCD ones digit to load.
REQ-007 The block SHALL have port start_pause  input  1  one-cycle pulse toggling run/pause.
REQ-008 The block SHALL have port dig_tens  output  4  current tens digit (feeds display in2).
REQ-009 The block SHALL have port dig_ones  output  4  current ones digit (feeds display in3).
REQ-010 The block SHALL have port running  output  1  high while in RUN.
REQ-011 The block SHALL have port done  output  1  high while in DONE.
REQ-012 The block SHALL have port zero_pulse  output  1  one-cycle pulse on the edge the count reaches 00.

Function
REQ-013 The state machine SHALL have exactly four states: IDLE, RUN, PAUSE and DONE.
REQ-014 Load SHALL take priority over start_pause in every state: digits take the preset values and the state goes to IDLE on the next edge.
REQ-015 Any preset digit greater than 9 SHALL be clamped to 9 on load.
REQ-016 In IDLE, start_pause SHALL move the state to RUN, unless the digits are 00, in which case it SHALL be ignored.
REQ-017 In RUN, each edge SHALL decrement the count by one in BCD: ones decrements; when ones is 0, ones becomes 9 and tens decrements.
REQ-018 In RUN, start_pause SHALL move the state to PAUSE on that edge without decrementing.
REQ-019 In PAUSE, the digits SHALL hold, and start_pause SHALL return the state to RUN.
REQ-020 On the RUN edge where the count goes 01->00, the state SHALL become DONE and zero_pulse SHALL be high for exactly that following cycle.
REQ-021 In DONE, the digits SHALL hold at 00 and start_pause SHALL be ignored; only load or reset exits DONE.
REQ-022 The count SHALL never wrap below 00.
REQ-023 running SHALL equal (state==RUN), done SHALL equal (state==DONE), and all outputs SHALL be registered.

Reset
REQ-024 On rst_n low, the block SHALL asynchronously set the state to IDLE, the digits to INIT_VAL, running, done and zero_pulse to 0, and the reload register to INIT_VAL.
REQ-025 Reset asserted mid-RUN SHALL abandon the count with no zero_pulse.

Configuration
REQ-026 When macro BCD_DOWN_RELOAD_EN is defined, a reload register SHALL capture every (clamped) load value.
REQ-027 With BCD_DOWN_RELOAD_EN defined, on reaching 00 the block SHALL still pulse zero_pulse but SHALL stay in RUN, and the next edge SHALL set the digits to the reload value.
REQ-028 With BCD_DOWN_RELOAD_EN defined, done SHALL never assert; if the reload value is 00, the block SHALL enter DONE as in the undefined case.
REQ-029 When BCD_DOWN_RELOAD_EN is undefined, the reload register and its logic SHALL be absent, and the behaviour SHALL be as specified in REQ-020 and REQ-021.

Structure
REQ-030 The shared package/header SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3) and the BCD_MAX=4'd9 constant.
REQ-031 A sub-module bcd_digit_dec SHALL provide single-digit BCD decrement with borrow-in/borrow-out and be instantiated twice, for ones and tens.

Verification
REQ-032 Bench SHALL cover: reset, load 25, start pulse -> running=1; digits 24, 23, ... 01, 00; zero_pulse on the 00 cycle; done=1 from then on, with the count held.
REQ-033 Bench SHALL cover: load 10, start, 1 edge -> 09 (borrow across the tens digit correct).
REQ-034 Bench SHALL cover: running at 17, start_pause -> PAUSE, digits hold 17 for 5 edges; start_pause -> resume 16, 15.
REQ-035 Bench SHALL cover: load with preset_tens=4'hC, preset_ones=4'hA -> digits 99; load and start_pause together -> IDLE, not RUN.
REQ-036 Bench SHALL cover: load 00 then start -> stays IDLE, done=0; in DONE, start_pause -> no change; rst_n low mid-count -> digits 30, IDLE immediately.
REQ-037 Bench SHALL cover, with BCD_DOWN_RELOAD_EN defined: load 03, start -> 02, 01, 00 (zero_pulse), 03, 02, ... with running held at 1 and done held at 0.

Source files
------------

// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the two-digit BCD down counter: FSM states,
// the largest BCD digit and the preset clamp helper.
package bcd_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement: with dec_en high the digit counts down,
// and 0 becomes 9 while raising borrow for the next digit up.
import bcd_down_counter_pkg::*;

module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic       dec_en,
    output logic [3:0] result,
    output logic       borrow
);

    always_comb begin
        result = digit;
        borrow = 1'b0;
        if (dec_en) begin
            if (digit == 4'd0) begin
                result = BCD_MAX;
                borrow = 1'b1;
            end else begin
                result = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Two-digit BCD countdown timer with run/pause control and a zero pulse.
// Define BCD_DOWN_RELOAD_EN to reload the last loaded value on reaching 00.
import bcd_down_counter_pkg::*;

module bcd_down_counter #(
    parameter logic [7:0] INIT_VAL = 8'h30
) (
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic       start_pause,
    output logic [3:0] dig_tens,
    output logic [3:0] dig_ones,
    output logic       running,
    output logic       done,
    output logic       zero_pulse
);

    state_t     state;
    logic [3:0] ones_dec;
    logic [3:0] tens_dec;
    logic       ones_borrow;
    logic       at_zero;
    logic       at_one;

`ifdef BCD_DOWN_RELOAD_EN
    logic [7:0] reload_val;
`endif

    bcd_digit_dec u_ones (
        .digit  (dig_ones),
        .dec_en (1'b1),
        .result (ones_dec),
        .borrow (ones_borrow)
    );

    // A borrow out of the tens digit means the count is already 00.
    bcd_digit_dec u_tens (
        .digit  (dig_tens),
        .dec_en (ones_borrow),
        .result (tens_dec),
        .borrow (at_zero)
    );

    assign at_one = (dig_tens == 4'd0) && (dig_ones == 4'd1);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dig_tens   <= INIT_VAL[7:4];
            dig_ones   <= INIT_VAL[3:0];
            running    <= 1'b0;
            done       <= 1'b0;
            zero_pulse <= 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
            reload_val <= INIT_VAL;
`endif
        end else begin
            zero_pulse <= 1'b0;
            if (load) begin
                state    <= IDLE;
                dig_tens <= bcd_clamp(preset_tens);
                dig_ones <= bcd_clamp(preset_ones);
                running  <= 1'b0;
                done     <= 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
                reload_val <= {bcd_clamp(preset_tens), bcd_clamp(preset_ones)};
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start_pause && !at_zero) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (start_pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (at_zero) begin
`ifdef BCD_DOWN_RELOAD_EN
                            dig_tens <= reload_val[7:4];
                            dig_ones <= reload_val[3:0];
`else
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
`endif
                        end else begin
                            dig_tens <= tens_dec;
                            dig_ones <= ones_dec;
                            if (at_one) begin
                                zero_pulse <= 1'b1;
`ifdef BCD_DOWN_RELOAD_EN
                                if (reload_val == 8'h00) begin
                                    state   <= DONE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end
`else
                                state   <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
`endif
                            end
                        end
                    end
                    PAUSE: begin
                        if (start_pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: stimulus queues the expected
// outputs for each edge, a monitor pops and compares after the edge.
module tb_bcd_down_counter;

    logic       clk_out = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic       start_pause;
    logic [3:0] dig_tens;
    logic [3:0] dig_ones;
    logic       running;
    logic       done;
    logic       zero_pulse;

    typedef struct {
        string      name;
        logic [10:0] val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    bcd_down_counter #(.INIT_VAL(8'h30)) dut (
        .clk_out     (clk_out),
        .rst_n       (rst_n),
        .load        (load),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .start_pause (start_pause),
        .dig_tens    (dig_tens),
        .dig_ones    (dig_ones),
        .running     (running),
        .done        (done),
        .zero_pulse  (zero_pulse)
    );

    always #5 clk_out = ~clk_out;

    function automatic logic [10:0] pack(input int t, input int o,
                                         input logic r, input logic d, input logic z);
        logic [3:0] tt;
        logic [3:0] oo;
        tt = 4'(t);
        oo = 4'(o);
        return {tt, oo, r, d, z};
    endfunction

    task automatic compare(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {dig_tens, dig_ones, running, done, zero_pulse};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got tens=%h ones=%h run=%b done=%b zp=%b, want tens=%h ones=%h run=%b done=%b zp=%b",
                     name, act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: the DUT presents a new output after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_out);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                compare(e.name, e.val);
            end
        end
    end

    // Drive one edge's inputs at the falling edge and queue its expected result.
    task automatic cyc(input string name, input logic l, input logic [3:0] pt,
                       input logic [3:0] po, input logic sp,
                       input int et, input int eo, input logic er, input logic ed, input logic ez);
        exp_t e;
        load        = l;
        preset_tens = pt;
        preset_ones = po;
        start_pause = sp;
        e.name = name;
        e.val  = pack(et, eo, er, ed, ez);
        q.push_back(e);
        @(posedge clk_out);
        @(negedge clk_out);
        load        = 1'b0;
        start_pause = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        preset_tens = 4'd0;
        preset_ones = 4'd0;
        start_pause = 1'b0;
        #12;
        compare("reset_state", pack(3, 0, 0, 0, 0));
        @(negedge clk_out);
        rst_n = 1'b1;

`ifdef BCD_DOWN_RELOAD_EN
        cyc("load03", 1, 4'd0, 4'd3, 0, 0, 3, 0, 0, 0);
        cyc("start03", 0, 4'd0, 4'd0, 1, 0, 3, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cyc("rl_02", 0, 4'd0, 4'd0, 0, 0, 2, 1, 0, 0);
            cyc("rl_01", 0, 4'd0, 4'd0, 0, 0, 1, 1, 0, 0);
            cyc("rl_00_pulse", 0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 1);
            cyc("rl_reload03", 0, 4'd0, 4'd0, 0, 0, 3, 1, 0, 0);
        end
        cyc("rl_02_again", 0, 4'd0, 4'd0, 0, 0, 2, 1, 0, 0);
`else
        cyc("load25", 1, 4'd2, 4'd5, 0, 2, 5, 0, 0, 0);
        cyc("start25", 0, 4'd0, 4'd0, 1, 2, 5, 1, 0, 0);
        for (int n = 24; n >= 1; n--)
            cyc("count25", 0, 4'd0, 4'd0, 0, n / 10, n % 10, 1, 0, 0);
        cyc("reach00_pulse", 0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1);
        cyc("done_hold", 0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0);
        cyc("done_ignore_sp", 0, 4'd0, 4'd0, 1, 0, 0, 0, 1, 0);
        cyc("done_hold2", 0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0);
`endif

        cyc("load10", 1, 4'd1, 4'd0, 0, 1, 0, 0, 0, 0);
        cyc("start10", 0, 4'd0, 4'd0, 1, 1, 0, 1, 0, 0);
        cyc("borrow09", 0, 4'd0, 4'd0, 0, 0, 9, 1, 0, 0);

        cyc("load17", 1, 4'd1, 4'd7, 0, 1, 7, 0, 0, 0);
        cyc("start17", 0, 4'd0, 4'd0, 1, 1, 7, 1, 0, 0);
        cyc("pause17", 0, 4'd0, 4'd0, 1, 1, 7, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            cyc("pause_hold", 0, 4'd0, 4'd0, 0, 1, 7, 0, 0, 0);
        cyc("resume17", 0, 4'd0, 4'd0, 1, 1, 7, 1, 0, 0);
        cyc("resume16", 0, 4'd0, 4'd0, 0, 1, 6, 1, 0, 0);
        cyc("resume15", 0, 4'd0, 4'd0, 0, 1, 5, 1, 0, 0);

        cyc("clamp99", 1, 4'hC, 4'hA, 0, 9, 9, 0, 0, 0);
        cyc("load_beats_sp", 1, 4'd1, 4'd2, 1, 1, 2, 0, 0, 0);
        cyc("idle_hold12", 0, 4'd0, 4'd0, 0, 1, 2, 0, 0, 0);

        cyc("load00", 1, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
        cyc("start00_ignored", 0, 4'd0, 4'd0, 1, 0, 0, 0, 0, 0);

        cyc("load05", 1, 4'd0, 4'd5, 0, 0, 5, 0, 0, 0);
        cyc("start05", 0, 4'd0, 4'd0, 1, 0, 5, 1, 0, 0);
        cyc("count04", 0, 4'd0, 4'd0, 0, 0, 4, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        compare("async_reset_mid", pack(3, 0, 0, 0, 0));
        @(negedge clk_out);
        rst_n = 1'b1;
        cyc("after_reset_idle", 0, 4'd0, 4'd0, 0, 3, 0, 0, 0, 0);
        cyc("start30", 0, 4'd0, 4'd0, 1, 3, 0, 1, 0, 0);
        cyc("borrow29", 0, 4'd0, 4'd0, 0, 2, 9, 1, 0, 0);

        repeat (2) @(posedge clk_out);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
